// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program counter.
//   PC_AW, PC_INC, PC_RESET, RAS_DEPTH_DEF : default parameter values
//   npc_sel_e                              : next-PC mux select
package pc_pkg;

  localparam int unsigned PC_AW         = 8;
  localparam int unsigned PC_INC        = 4;
  localparam int unsigned PC_RESET      = 0;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_BRANCH,
    SEL_HOLD,
    SEL_RET,
    SEL_SEQ
  } npc_sel_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with overwrite-on-overflow.
//   clk, reset : clock, synchronous active-high reset
//   push, pop  : stack operations (both together replace the top entry)
//   din        : address pushed
//   top        : current top entry (valid when !empty)
//   empty/full : derived from the registered entry count
//   err        : sticky; push-when-full or pop-when-empty, cleared by reset
// DEPTH must be at least 2.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW    = PC_AW,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [CW-1:0] count;
  logic          do_replace;
  logic          do_push;
  logic          do_pop;

  // Pointer wrap written explicitly so non-power-of-two depths work.
  assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = mem[ptr];

  // Push+pop on a non-empty stack is a top replacement; on an empty stack
  // it degrades to a plain push (the failed pop still flags err).
  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = push & pop & ~empty;
    do_push    = push & ~do_replace;
    do_pop     = pop & ~push & ~empty;
  end

  // Pointer, count and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push) begin
        ptr <= ptr_inc;
        // When full the oldest entry is overwritten and count saturates.
        if (!full) count <= count + CW'(1);
      end else if (do_pop) begin
        ptr   <= ptr_dec;
        count <= count - CW'(1);
      end
      if ((do_push & full) | (pop & empty)) err <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push)         mem[ptr_inc] <= din;
      else if (do_replace) mem[ptr]     <= din;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with branch redirect and return-address stack.
//   clk, reset        : clock, synchronous active-high reset
//   E                 : fetch enable (0 = stall, PC held)
//   branch_taken      : redirect request; wins over a stall
//   branch_target     : redirect address
//   call, ret         : push pc_plus / pop into PC; ignored while stalled
//   pc                : registered fetch PC
//   pc_plus           : pc + INC, combinational from pc, wraps mod 2^AW
//   redirect          : registered, high the cycle after a branch/return load
//   ras_empty/full    : stack occupancy flags
//   ras_err           : sticky stack over/underflow flag
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned AW        = PC_AW,
  parameter int unsigned INC       = PC_INC,
  parameter int unsigned RESET_PC  = PC_RESET,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          E,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus,
  output logic          redirect,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  logic          adv;
  logic          ras_push;
  logic          ras_pop;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] pc_next;
  npc_sel_e      sel;

  assign pc_plus = pc + AW'(INC);

  // A branch advances fetch even during a stall; call/ret need an advance.
  assign adv      = E | branch_taken;
  assign ras_push = call & adv;
  assign ras_pop  = ret & adv;

  return_stack #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .err   (ras_err)
  );

  // Next-PC select in priority order.
  always_comb begin
    sel = SEL_SEQ;
    if (reset)                  sel = SEL_RESET;
    else if (branch_taken)      sel = SEL_BRANCH;
    else if (!E)                sel = SEL_HOLD;
    else if (ret && !ras_empty) sel = SEL_RET;
  end

  always_comb begin
    pc_next = pc_plus;
    unique case (sel)
      SEL_RESET:  pc_next = AW'(RESET_PC);
      SEL_BRANCH: pc_next = branch_target;
      SEL_HOLD:   pc_next = pc;
      SEL_RET:    pc_next = ras_top;
      default:    pc_next = pc_plus;
    endcase
  end

  // PC register and one-cycle redirect flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= AW'(RESET_PC);
      redirect <= 1'b0;
    end else begin
      pc       <= pc_next;
      redirect <= (sel == SEL_BRANCH) || (sel == SEL_RET);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (default parameters).
// A behavioural model (queue-based stack) predicts each cycle's outputs;
// predictions are queued when inputs are driven and checked after the edge.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       E;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       call;
  logic       ret;
  logic [7:0] pc;
  logic [7:0] pc_plus;
  logic       redirect;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .E             (E),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .redirect      (redirect),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic       red;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_stack[$];
  logic [7:0] m_pc  = 8'h00;
  logic       m_err = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_step = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict with the model, then check after the edge.
  task automatic step(input bit rst, input bit e, input bit b,
                      input logic [7:0] t, input bit c, input bit r);
    exp_t       x;
    logic [7:0] pp;
    logic       mt;
    bit         adv;
    reset = rst; E = e; branch_taken = b; branch_target = t; call = c; ret = r;
    pp  = m_pc + 8'd4;
    mt  = (m_stack.size() == 0);
    adv = e | b;
    x.red = 1'b0;
    if (rst) begin
      m_pc = 8'h00;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      if (b) begin
        m_pc = t; x.red = 1'b1;
      end else if (!e) begin
        m_pc = m_pc;
      end else if (r && !mt) begin
        m_pc = m_stack[$]; x.red = 1'b1;
      end else begin
        m_pc = pp;
      end
      if (adv && c && r && !mt) begin
        m_stack[m_stack.size()-1] = pp;
      end else if (adv && c) begin
        if (m_stack.size() == 4) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_stack.push_back(pp);
        if (r) m_err = 1'b1;
      end else if (adv && r) begin
        if (mt) m_err = 1'b1;
        else void'(m_stack.pop_back());
      end
    end
    x.pc    = m_pc;
    x.err   = m_err;
    x.empty = (m_stack.size() == 0);
    x.full  = (m_stack.size() == 4);
    sb.push_back(x);
    @(posedge clk);
    #1;
    n_step++;
    if (sb.size() == 0) begin
      chk($sformatf("s%0d_sb_empty", n_step), 8'h01, 8'h00);
    end else begin
      x = sb.pop_front();
      chk($sformatf("s%0d_pc", n_step),       pc,                x.pc);
      chk($sformatf("s%0d_pc_plus", n_step),  pc_plus,           x.pc + 8'd4);
      chk($sformatf("s%0d_redirect", n_step), {7'd0, redirect},  {7'd0, x.red});
      chk($sformatf("s%0d_empty", n_step),    {7'd0, ras_empty}, {7'd0, x.empty});
      chk($sformatf("s%0d_full", n_step),     {7'd0, ras_full},  {7'd0, x.full});
      chk($sformatf("s%0d_err", n_step),      {7'd0, ras_err},   {7'd0, x.err});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; E = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    call = 1'b0; ret = 1'b0;

    // 1: sequential advance from reset
    step(1, 0, 0, 8'h00, 0, 0);
    chk("reset_pc", pc, 8'h00);
    chk("reset_empty", {7'd0, ras_empty}, 8'h01);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0, 0);
    chk("seq_pc_10", pc, 8'h10);

    // 2: stall holds, branch during stall redirects for one cycle
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, 0);
    chk("stall_hold", pc, 8'h10);
    step(0, 0, 1, 8'h80, 0, 0);
    chk("stall_branch_pc", pc, 8'h80);
    chk("stall_branch_red", {7'd0, redirect}, 8'h01);
    step(0, 1, 0, 8'h00, 0, 0);
    chk("redirect_one_cycle", {7'd0, redirect}, 8'h00);

    // 1b: wrap from 0xF8
    step(0, 1, 1, 8'hF8, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    chk("wrap_fc", pc, 8'hFC);
    chk("wrap_pc_plus", pc_plus, 8'h00);
    step(0, 1, 0, 8'h00, 0, 0);
    chk("wrap_00", pc, 8'h00);
    chk("wrap_no_red", {7'd0, redirect}, 8'h00);

    // 3: call+branch then return
    step(0, 1, 1, 8'h20, 0, 0);
    step(0, 1, 1, 8'h60, 1, 0);
    chk("call_pc", pc, 8'h60);
    step(0, 1, 0, 8'h00, 0, 0);
    chk("call_at_64", pc, 8'h64);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("ret_pc", pc, 8'h24);
    chk("ret_red", {7'd0, redirect}, 8'h01);
    chk("ret_empty", {7'd0, ras_empty}, 8'h01);

    // 4: overflow loses oldest entry
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 1, 8'h10, 1, 0);
    step(0, 1, 1, 8'h20, 1, 0);
    step(0, 1, 1, 8'h30, 1, 0);
    step(0, 1, 1, 8'h40, 1, 0);
    step(0, 1, 1, 8'h70, 1, 0);
    chk("ovf_full", {7'd0, ras_full}, 8'h01);
    chk("ovf_err", {7'd0, ras_err}, 8'h01);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("ovf_ret0", pc, 8'h44);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("ovf_ret1", pc, 8'h34);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("ovf_ret2", pc, 8'h24);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("ovf_ret3", pc, 8'h14);
    chk("ovf_drained", {7'd0, ras_empty}, 8'h01);

    // Stalled call/ret are ignored
    step(0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 0, 1);
    chk("stall_call_ignored", {7'd0, ras_empty}, 8'h01);

    // 5: underflow, then call+ret replace
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("udf_pc", pc, 8'h0C);
    chk("udf_err", {7'd0, ras_err}, 8'h01);
    chk("udf_no_red", {7'd0, redirect}, 8'h00);
    step(0, 1, 1, 8'h20, 0, 0);
    step(0, 1, 1, 8'h50, 1, 0);
    step(0, 1, 0, 8'h00, 1, 1);
    chk("callret_pc", pc, 8'h24);
    step(0, 1, 0, 8'h00, 0, 1);
    chk("callret_newtop", pc, 8'h54);
    // ret with branch: pop happens, PC takes target
    step(0, 1, 0, 8'h00, 1, 0);
    step(0, 1, 1, 8'hA0, 0, 1);
    chk("retbr_pc", pc, 8'hA0);
    chk("retbr_popped", {7'd0, ras_empty}, 8'h01);
    // call+ret while empty acts as push with error
    step(0, 1, 0, 8'h00, 1, 1);
    chk("callret_empty_pc", pc, 8'hA4);

    // 6: reset mid-operation
    step(0, 1, 0, 8'h00, 1, 0);
    step(0, 1, 0, 8'h00, 1, 0);
    step(1, 0, 0, 8'h00, 1, 1);
    chk("rst_mid_pc", pc, 8'h00);
    chk("rst_mid_empty", {7'd0, ras_empty}, 8'h01);
    chk("rst_mid_err", {7'd0, ras_err}, 8'h00);
    chk("rst_mid_red", {7'd0, redirect}, 8'h00);
    step(0, 1, 0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
